// File: rtl/bgm_pkg.sv
// bgm_pkg: shared constants, note table and FSM encoding
// for the background-music player.
package bgm_pkg;

    localparam logic [25:0] SILENCE = 26'd50000000;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        PLAY,
        DONE
    } state_t;

    // Code 0 is a rest; codes 1..63 run chromatically from C2.
    localparam int NOTE_HZ [64] = '{
        50000000,
        65, 69, 73, 78, 82, 87, 92, 98, 104, 110, 117, 123,
        131, 139, 147, 156, 165, 175, 185, 196, 208, 220, 233, 247,
        262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494,
        523, 554, 587, 622, 659, 698, 740, 784, 831, 880, 932, 988,
        1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568,
        1661, 1760, 1865, 1976,
        2093, 2217, 2349
    };

endpackage

// File: rtl/bgm_player_if.sv
// bgm_player_if: game-FSM controls in, stereo tone
// frequencies and play status out.
interface bgm_player_if #(
    parameter int TRK_W  = 3,
    parameter int ADDR_W = 12
);
    logic              play_en;
    logic [TRK_W-1:0]  track_sel;
    logic              mute;
    logic [25:0]       freqL;
    logic [25:0]       freqR;
    logic [ADDR_W-1:0] note_addr;
    logic              playing;
    logic              done;
    logic              beat;

    modport master (
        output play_en, track_sel, mute,
        input  freqL, freqR, note_addr, playing, done, beat
    );

    modport slave (
        input  play_en, track_sel, mute,
        output freqL, freqR, note_addr, playing, done, beat
    );
endinterface

// File: rtl/bgm_note_rom.sv
// bgm_note_rom: synchronous-read note ROM, word {noteL, noteR}
// at {track, note_addr}; out-of-range tracks read as rests.
module bgm_note_rom #(
    parameter int NUM_TRACKS = 8,
    parameter int ADDR_W     = 12,
    parameter int TRK_W      = 3,
    parameter logic [NUM_TRACKS*(2**ADDR_W)*12-1:0] ROM_IMAGE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TRK_W-1:0]  i_trk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [11:0]       o_data
);
    localparam int DEPTH = NUM_TRACKS * (2**ADDR_W);

    logic [TRK_W+ADDR_W-1:0] w_idx;
    logic [11:0]             r_data;

    assign w_idx  = {i_trk, i_addr};
    assign o_data = r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (32'(w_idx) < 32'(DEPTH)) begin
            r_data <= ROM_IMAGE[w_idx*12 +: 12];
        end else begin
            r_data <= '0;
        end
    end
endmodule

// File: rtl/bgm_player.sv
// bgm_player: multi-track stereo music engine with beat
// prescaler, per-track tempo, loop/one-shot and silent gap.
module bgm_player
    import bgm_pkg::*;
#(
    parameter int NUM_TRACKS = 8,
    parameter int ADDR_W     = 12,
    parameter int TICK_DIV   = 2097152,
    parameter int GAP_BEATS  = 2,
    parameter logic [NUM_TRACKS*ADDR_W-1:0] TRACK_LEN   = '1,
    parameter logic [NUM_TRACKS*4-1:0]      TRACK_TEMPO = '0,
    parameter logic [NUM_TRACKS-1:0]        LOOP_MASK   = '1,
    parameter logic [NUM_TRACKS*(2**ADDR_W)*12-1:0] ROM_IMAGE = '0
) (
    input logic         clk,
    input logic         rst,
    bgm_player_if.slave bus
);
    localparam int TRK_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = $clog2(GAP_BEATS + 1);

    state_t            r_state, w_state;
    logic [PW-1:0]     r_presc;
    logic [3:0]        r_tempo, w_tempo, w_tmax;
    logic [GW-1:0]     r_gap, w_gap;
    logic [TRK_W-1:0]  r_trk, w_trk, w_tidx;
    logic [ADDR_W-1:0] r_addr, w_addr, w_len;
    logic              w_valid, w_loop, w_tick, w_beat;
    logic [11:0]       w_rom;
    logic [25:0]       r_freqL, r_freqR;

    // Invalid tracks behave as one-beat looping tracks of rests.
    assign w_valid = 32'(r_trk) < 32'(NUM_TRACKS);
    assign w_tidx  = w_valid ? r_trk : '0;
    assign w_len   = w_valid ? TRACK_LEN[w_tidx*ADDR_W +: ADDR_W]
                             : ADDR_W'(1);
    assign w_tmax  = w_valid ? TRACK_TEMPO[w_tidx*4 +: 4] : 4'd0;
    assign w_loop  = w_valid ? LOOP_MASK[w_tidx] : 1'b1;
    assign w_tick  = r_presc == PW'(TICK_DIV - 1);
    assign w_beat  = w_tick && (r_tempo == w_tmax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_trk   <= '0;
            r_addr  <= '0;
            r_gap   <= '0;
            r_tempo <= '0;
        end else begin
            r_state <= w_state;
            r_trk   <= w_trk;
            r_addr  <= w_addr;
            r_gap   <= w_gap;
            r_tempo <= w_tempo;
        end
    end

    always_comb begin
        w_state = r_state;
        w_trk   = r_trk;
        w_addr  = r_addr;
        w_gap   = r_gap;
        w_tempo = r_tempo;
        if (w_tick) begin
            w_tempo = w_beat ? 4'd0 : r_tempo + 4'd1;
        end
        if (!bus.play_en) begin
            w_state = IDLE;
            w_addr  = '0;
        end else if (r_state == IDLE || bus.track_sel != r_trk) begin
            // A (re)start discards any beat landing in this cycle.
            w_state = GAP;
            w_trk   = bus.track_sel;
            w_addr  = '0;
            w_gap   = '0;
            w_tempo = '0;
        end else if (w_beat) begin
            unique case (r_state)
                GAP: begin
                    if (r_gap == GW'(GAP_BEATS - 1)) begin
                        w_state = PLAY;
                        w_addr  = '0;
                    end else begin
                        w_gap = r_gap + 1'b1;
                    end
                end
                PLAY: begin
                    if (r_addr == w_len - 1'b1) begin
                        if (w_loop) begin
                            w_addr = '0;
                        end else begin
                            w_state = DONE;
                        end
                    end else begin
                        w_addr = r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bgm_note_rom #(
        .NUM_TRACKS (NUM_TRACKS),
        .ADDR_W     (ADDR_W),
        .TRK_W      (TRK_W),
        .ROM_IMAGE  (ROM_IMAGE)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_trk  (r_trk),
        .i_addr (r_addr),
        .o_data (w_rom)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_freqL <= SILENCE;
            r_freqR <= SILENCE;
        end else if (bus.mute || r_state != PLAY || !w_valid) begin
            r_freqL <= SILENCE;
            r_freqR <= SILENCE;
        end else begin
            r_freqL <= 26'(NOTE_HZ[w_rom[11:6]]);
            r_freqR <= 26'(NOTE_HZ[w_rom[5:0]]);
        end
    end

    assign bus.freqL     = r_freqL;
    assign bus.freqR     = r_freqR;
    assign bus.note_addr = r_addr;
    assign bus.playing   = r_state == PLAY;
    assign bus.done      = r_state == DONE;
    assign bus.beat      = w_beat;
endmodule

// File: tb/tb_bgm_player.sv
// tb_bgm_player: directed stimulus with a cycle model of the
// player checked every cycle, plus hand-computed pins.
module tb_bgm_player;
    localparam int NT = 5;
    localparam int AW = 4;
    localparam logic [25:0] SIL = 26'd50000000;
    localparam int M_IDLE = 0, M_GAP = 1, M_PLAY = 2, M_DONE = 3;

    function automatic logic [11:0] rom_word(input int i);
        case (i)
            0:  return {6'd34, 6'd22};
            1:  return {6'd25, 6'd0};
            2:  return {6'd29, 6'd32};
            3:  return {6'd37, 6'd10};
            16: return {6'd46, 6'd49};
            17: return {6'd0,  6'd0};
            18: return {6'd32, 6'd25};
            32: return {6'd49, 6'd34};
            33: return {6'd10, 6'd46};
            default: return 12'd0;
        endcase
    endfunction

    function automatic logic [NT*16*12-1:0] build_img();
        logic [NT*16*12-1:0] v;
        v = '0;
        for (int i = 0; i < NT*16; i++) v[i*12 +: 12] = rom_word(i);
        return v;
    endfunction

    localparam logic [NT*16*12-1:0] ROM_IMG = build_img();

    function automatic logic [25:0] hz(input logic [5:0] c);
        case (c)
            6'd0:  return SIL;
            6'd10: return 26'd110;
            6'd22: return 26'd220;
            6'd25: return 26'd262;
            6'd29: return 26'd330;
            6'd32: return 26'd392;
            6'd34: return 26'd440;
            6'd37: return 26'd523;
            6'd46: return 26'd880;
            6'd49: return 26'd1047;
            default: return 26'h3ffffff;
        endcase
    endfunction

    function automatic int tlen(input int t);
        case (t)
            0: return 4;
            1: return 3;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bgm_player_if #(.TRK_W(3), .ADDR_W(AW)) bus ();

    bgm_player #(
        .NUM_TRACKS  (NT),
        .ADDR_W      (AW),
        .TICK_DIV    (4),
        .GAP_BEATS   (2),
        .TRACK_LEN   ({4'd1, 4'd1, 4'd2, 4'd3, 4'd4}),
        .TRACK_TEMPO (20'd0),
        .LOOP_MASK   (5'b11101),
        .ROM_IMAGE   (ROM_IMG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Model: beats fall every 4th clock after reset release;
    // freq reflects the ROM word read one cycle earlier.
    int          m_cyc = 0, m_st = M_IDLE, m_trk = 0;
    int          m_addr = 0, m_gap = 0;
    logic [11:0] m_q = '0;
    logic [25:0] m_fl = SIL, m_fr = SIL;
    logic [11:0] m_nq;
    bit          m_bt, m_on;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc = 0; m_st = M_IDLE; m_trk = 0;
            m_addr = 0; m_gap = 0; m_q = '0;
            m_fl = SIL; m_fr = SIL;
        end else begin
            m_bt = (m_cyc % 4) == 3;
            m_on = m_st == M_PLAY && !bus.mute && m_trk < NT;
            m_fl = m_on ? hz(m_q[11:6]) : SIL;
            m_fr = m_on ? hz(m_q[5:0]) : SIL;
            m_nq = (m_trk < NT) ? rom_word(m_trk*16 + m_addr) : 12'd0;
            if (!bus.play_en) begin
                m_st = M_IDLE;
                m_addr = 0;
            end else if (m_st == M_IDLE || int'(bus.track_sel) != m_trk) begin
                m_st = M_GAP;
                m_trk = int'(bus.track_sel);
                m_addr = 0;
                m_gap = 2;
            end else if (m_bt && m_st == M_GAP) begin
                m_gap--;
                if (m_gap == 0) m_st = M_PLAY;
            end else if (m_bt && m_st == M_PLAY) begin
                if (m_addr + 1 == tlen(m_trk)) begin
                    if (m_trk == 1) m_st = M_DONE;
                    else m_addr = 0;
                end else begin
                    m_addr++;
                end
            end
            m_q = m_nq;
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("freqL", 32'(bus.freqL), 32'(m_fl));
            chk("freqR", 32'(bus.freqR), 32'(m_fr));
            chk("note_addr", 32'(bus.note_addr), 32'(m_addr));
            chk("playing", 32'(bus.playing), 32'(m_st == M_PLAY));
            chk("done", 32'(bus.done), 32'(m_st == M_DONE));
            chk("beat", 32'(bus.beat), 32'((m_cyc % 4) == 3));
        end
    end

    task automatic at(input int k);
        int g;
        g = 0;
        while (m_cyc < k && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (m_cyc != k) begin
            n_tests++;
            n_fail++;
            $display("FAIL reach_cycle: got %0d expected %0d", m_cyc, k);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.play_en = 1'b0;
        bus.track_sel = 3'd0;
        bus.mute = 1'b0;
        #12;
        chk("rst_freqL", 32'(bus.freqL), 32'(SIL));
        chk("rst_freqR", 32'(bus.freqR), 32'(SIL));
        chk("rst_addr", 32'(bus.note_addr), 0);
        chk("rst_playing", 32'(bus.playing), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_beat", 32'(bus.beat), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.play_en = 1'b1;

        at(7);  chk("gap_sil", 32'(bus.freqL), 32'(SIL));
        chk("gap_play", 32'(bus.playing), 0);
        at(9);  chk("t0a0_L", 32'(bus.freqL), 440);
        chk("t0a0_R", 32'(bus.freqR), 220);
        at(14); chk("t0a1_L", 32'(bus.freqL), 262);
        chk("t0a1_rest", 32'(bus.freqR), 32'(SIL));
        at(17); chk("t0_addr2", 32'(bus.note_addr), 2);
        at(18); chk("t0a2_L", 32'(bus.freqL), 330);
        at(22); chk("t0a3_R", 32'(bus.freqR), 110);
        at(24); chk("t0_wrap", 32'(bus.note_addr), 0);

        at(25); bus.mute = 1'b1;
        at(26); chk("mute_sil", 32'(bus.freqL), 32'(SIL));
        at(29); chk("mute_addr", 32'(bus.note_addr), 1);
        bus.mute = 1'b0;
        at(30); chk("unmute_L", 32'(bus.freqL), 262);

        at(31); bus.track_sel = 3'd2;
        at(32); chk("chg_addr", 32'(bus.note_addr), 0);
        chk("chg_gap", 32'(bus.playing), 0);
        at(39); chk("chg_gap2", 32'(bus.playing), 0);
        at(41); chk("t2a0_L", 32'(bus.freqL), 1047);
        at(46); chk("t2a1_R", 32'(bus.freqR), 880);

        bus.track_sel = 3'd1;
        at(53); chk("t1a0_L", 32'(bus.freqL), 880);
        at(58); chk("t1_rest", 32'(bus.freqL), 32'(SIL));
        at(62); chk("t1a2_R", 32'(bus.freqR), 262);
        at(64); chk("t1_done", 32'(bus.done), 1);
        chk("t1_notplay", 32'(bus.playing), 0);
        at(65); chk("done_sil", 32'(bus.freqL), 32'(SIL));
        at(72); chk("done_hold", 32'(bus.done), 1);

        bus.track_sel = 3'd5;
        at(82); chk("inv_play", 32'(bus.playing), 1);
        chk("inv_sil", 32'(bus.freqR), 32'(SIL));
        at(90); bus.play_en = 1'b0;
        at(91); chk("stop_idle", 32'(bus.playing), 0);

        at(95); bus.track_sel = 3'd0; bus.play_en = 1'b1;
        at(110); chk("restart_addr", 32'(bus.note_addr), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_freqL", 32'(bus.freqL), 32'(SIL));
        chk("arst_playing", 32'(bus.playing), 0);
        chk("arst_addr", 32'(bus.note_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        at(9);  chk("rerun_L", 32'(bus.freqL), 440);
        at(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
